lut4_vector_checker: RTL and testbench
======================================

# lut4_vector_checker

Synthesizable stimulus-and-check stage for the LUT4 install test: it drives all 16 input vectors into the `top` LUT4 design under test (the `I[3:0]` bus), waits a programmable settle time per vector, samples the returned `O`, and compares it against an expected truth table. It sits directly upstream of the DUT inputs and downstream of its output, so the LUT4 can be checked on hardware without the simulation bench. Results are a pass flag, a mismatch count, and the first failing vector.

## Interface
- `SETTLE_CYCLES`, 4: cycles `i_vec` is held before sampling; legal range 1..255.
- `EXPECTED`, 16'h5F5F: expected `O` per input value, bit n = `O` for `I` = n. The default is `O = ~(I[0] & I[2])`.

- `clk`  in  1  single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse begins a run; honoured only in IDLE or DONE.
- `i_vec`  out  4  drives DUT `I[3:0]`; registered.
- `o_in`  in  1  DUT `O`; registered once internally (`o_q`) before comparison.
- `busy`  out  1  high in SETTLE/SAMPLE.
- `done`  out  1  high in DONE until the next `start` or `rst`.
- `pass`  out  1  `done && err_count == 0`.
- `err_count`  out  5  mismatches in the current or last run, 0..16.
- `fail_valid`  out  1  at least one mismatch has been recorded this run.
- `fail_vec`  out  4  first mismatching input value; valid when `fail_valid`.

## Operation
- States:
  - IDLE: `start` goes to SETTLE.
  - SETTLE: counts `SETTLE_CYCLES` cycles, then goes to SAMPLE.
  - SAMPLE: one cycle, then SETTLE with the next vector, or DONE after vector 15.
  - DONE: `start` goes to SETTLE.
- Vector order is ascending binary, 0..15. `i_vec` is loaded with the new value on entry to SETTLE.
- In SAMPLE, compare `o_q` against `EXPECTED[i_vec]`. On a mismatch:
  - `err_count` increments; it saturates at 16 and cannot exceed it.
  - If `fail_valid` is 0, latch `fail_vec <= i_vec` and set `fail_valid`.
- `start` in IDLE or DONE resets the run state in the same edge:
  - clears `err_count`, `fail_valid` and `fail_vec`;
  - sets `i_vec` to 0;
  - clears `done`.
- `start` during SETTLE/SAMPLE is ignored; the run continues unchanged.
- `rst` at any time, including mid-run, forces IDLE on the next edge and aborts the run with no partial result.
- Reset values of all outputs:
  - `i_vec` = 0;
  - `busy`, `done`, `pass` = 0;
  - `err_count` = 0;
  - `fail_valid` = 0, `fail_vec` = 0.
- `i_vec` holds its last value (15) in DONE and 0 in IDLE after reset.

## Timing
- Edge 0 is the edge where `start` is sampled. At edge 0, `i_vec` = 0 and `busy` = 1.
- Each vector occupies `SETTLE_CYCLES + 1` cycles. The SAMPLE cycle for vector k is the cycle following edge 0 + k·(S+1) + S.
- `o_q` reflects `o_in` from one cycle earlier. The DUT therefore has S−1 full cycles plus its combinational path to settle; S=1 still works with a 1-cycle DUT path.
- Timing of the final vector:
  - `err_count` and `fail_*` update at the edge ending the vector-15 SAMPLE cycle.
  - `done` rises and `busy` falls at that same edge.
- Total run is 16·(S+1) cycles from edge 0 to `done`. For S=4 that is 80 cycles.
- `pass` is combinational from `done` and `err_count`; all other outputs are registered.

## Structure
- Package `lut4_test_pkg` contains:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - `VEC_COUNT` = 16;
  - `ERR_W` = 5;
  - `DEFAULT_EXPECTED` = 16'h5F5F.
- Sub-module `settle_timer`: 8-bit down-counter with `load`/`expired`, instantiated once. The FSM, vector counter and result registers live in the top module.

## Test plan
- **Reset sanity:** assert `rst` for 3 cycles, then release → all outputs 0 and state IDLE; `start` with no DUT connection is not required.
- **Matching DUT, S=4:** bench models `O = ~(I[0] & I[2])` → `done` after exactly 80 cycles, `pass` = 1, `err_count` = 0, `fail_valid` = 0.
- **Inverted DUT:** bench drives `O = I[0] & I[2]` → `err_count` = 16 (saturated), `fail_valid` = 1, `fail_vec` = 0.
- **Single stuck bit:** bench model is correct except `O` = 1 at `I` = 4'b0101 → `err_count` = 1, `fail_vec` = 5, `pass` = 0.
- **Mid-run reset and ignored start:**
  - pulse `start` again at cycle 10 → no effect;
  - assert `rst` at cycle 30 → IDLE next edge, `busy` = 0, `err_count` = 0.
- **Restart from DONE:** after a failing run, `start` → results cleared at edge 0; a clean second run ends with `pass` = 1.

Source files
------------

// File: rtl/lut4_test_pkg.sv
// Shared types and constants for the LUT4 vector checker.
package lut4_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam int          VEC_COUNT        = 16;
    localparam int          ERR_W            = 5;
    localparam logic [15:0] DEFAULT_EXPECTED = 16'h5F5F;

endpackage

// File: rtl/lut4_vector_checker_settle_timer.sv
// Down-counter timing how long each vector is held before sampling.
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       en_i,
    output logic       expired_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == 8'd0);

endmodule

// File: rtl/lut4_vector_checker.sv
// Walks all 16 LUT4 inputs, samples the DUT output and scores it
// against an expected truth table.
module lut4_vector_checker
    import lut4_test_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] EXPECTED      = DEFAULT_EXPECTED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       i_vec,
    input  logic             o_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [3:0]       fail_vec
);

    state_e           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fv_q, fv_d;
    logic [3:0]       fvec_q, fvec_d;
    logic             done_q, done_d;
    logic             o_q;
    logic             load;
    logic             expired;
    logic             mismatch;

    // Timer counts S-1 down to 0, so SETTLE lasts exactly S cycles.
    settle_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .load_val_i(8'(SETTLE_CYCLES - 1)),
        .en_i      (state_q == ST_SETTLE),
        .expired_o (expired)
    );

    assign mismatch = (o_q != EXPECTED[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fvec_d  = fvec_q;
        done_d  = done_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    vec_d   = 4'd0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fvec_d  = 4'd0;
                    done_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_W'(VEC_COUNT)) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fvec_d = vec_q;
                    end
                end
                if (vec_q == 4'(VEC_COUNT - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                    vec_d   = vec_q + 4'd1;
                    load    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 4'd0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= 4'd0;
            done_q  <= 1'b0;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
            done_q  <= done_d;
            o_q     <= o_in;
        end
    end

    assign i_vec      = vec_q;
    assign busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done       = done_q;
    assign pass       = done_q && (err_q == '0);
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_lut4_vector_checker.sv
// Directed bench: models good, inverted and stuck-bit LUT4s.
module tb_lut4_vector_checker;

    localparam int M_GOOD  = 0;
    localparam int M_INV   = 1;
    localparam int M_STUCK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] i_vec;
    logic       o_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       fail_valid;
    logic [3:0] fail_vec;

    int mode = M_GOOD;
    int checks = 0;
    int failures = 0;

    lut4_vector_checker #(
        .SETTLE_CYCLES(4),
        .EXPECTED     (16'h5F5F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .i_vec     (i_vec),
        .o_in      (o_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_valid(fail_valid),
        .fail_vec  (fail_vec)
    );

    always #5 clk = ~clk;

    function automatic logic lut_model(input int m, input logic [3:0] v);
        logic good;
        good = ~(v[0] & v[2]);
        if (m == M_INV) return ~good;
        if (m == M_STUCK && v == 4'b0101) return 1'b1;
        return good;
    endfunction

    always_comb o_in = lut_model(mode, i_vec);

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_vec, busy, done, pass, err_count, fail_valid, fail_vec} !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {i_vec, busy, done, pass, err_count, fail_valid, fail_vec});
        end
    endtask

    task automatic test_match();
        int n;
        mode = M_GOOD;
        start_run();
        checks++;
        if (busy !== 1'b1 || i_vec !== 4'd0) begin
            failures++;
            $display("FAIL edge0 busy=%b i_vec=%0d want busy=1 i_vec=0", busy, i_vec);
        end
        wait_done(n);
        checks++;
        if (n != 80) begin
            failures++;
            $display("FAIL match_latency got=%0d want=80", n);
        end
        checks++;
        if (pass !== 1'b1 || err_count !== 5'd0 || fail_valid !== 1'b0) begin
            failures++;
            $display("FAIL match_result pass=%b err=%0d fv=%b want 1 0 0",
                     pass, err_count, fail_valid);
        end
        checks++;
        if (busy !== 1'b0 || i_vec !== 4'd15) begin
            failures++;
            $display("FAIL done_state busy=%b i_vec=%0d want 0 15", busy, i_vec);
        end
    endtask

    task automatic test_inverted();
        int n;
        mode = M_INV;
        start_run();
        wait_done(n);
        checks++;
        if (n != 80) begin
            failures++;
            $display("FAIL inv_latency got=%0d want=80", n);
        end
        checks++;
        if (err_count !== 5'd16 || fail_valid !== 1'b1 || fail_vec !== 4'd0 || pass !== 1'b0) begin
            failures++;
            $display("FAIL inv_result err=%0d fv=%b fvec=%0d pass=%b want 16 1 0 0",
                     err_count, fail_valid, fail_vec, pass);
        end
    endtask

    task automatic test_stuck();
        int n;
        mode = M_STUCK;
        start_run();
        wait_done(n);
        checks++;
        if (n != 80) begin
            failures++;
            $display("FAIL stuck_latency got=%0d want=80", n);
        end
        checks++;
        if (err_count !== 5'd1 || fail_valid !== 1'b1 || fail_vec !== 4'd5 || pass !== 1'b0) begin
            failures++;
            $display("FAIL stuck_result err=%0d fv=%b fvec=%0d pass=%b want 1 1 5 0",
                     err_count, fail_valid, fail_vec, pass);
        end
    endtask

    task automatic test_midrun();
        mode = M_INV;
        start_run();
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (i_vec !== 4'd2 || err_count !== 5'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ignored_start i_vec=%0d err=%0d busy=%b want 2 2 1",
                     i_vec, err_count, busy);
        end
        repeat (19) @(negedge clk);
        checks++;
        if (err_count !== 5'd5 || fail_vec !== 4'd0) begin
            failures++;
            $display("FAIL pre_abort err=%0d fvec=%0d want 5 0", err_count, fail_vec);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({i_vec, busy, done, err_count, fail_valid} !== 11'd0) begin
            failures++;
            $display("FAIL abort i_vec=%0d busy=%b done=%b err=%0d fv=%b want all 0",
                     i_vec, busy, done, err_count, fail_valid);
        end
    endtask

    task automatic test_restart();
        int n;
        mode = M_INV;
        start_run();
        wait_done(n);
        checks++;
        if (err_count !== 5'd16 || done !== 1'b1) begin
            failures++;
            $display("FAIL restart_first err=%0d done=%b want 16 1", err_count, done);
        end
        mode = M_GOOD;
        start_run();
        checks++;
        if ({done, err_count, fail_valid, fail_vec, i_vec} !== 15'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear done=%b err=%0d fv=%b fvec=%0d i_vec=%0d busy=%b",
                     done, err_count, fail_valid, fail_vec, i_vec, busy);
        end
        wait_done(n);
        checks++;
        if (n != 80 || pass !== 1'b1 || err_count !== 5'd0) begin
            failures++;
            $display("FAIL restart_second n=%0d pass=%b err=%0d want 80 1 0",
                     n, pass, err_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_match();
        test_inverted();
        test_stuck();
        test_midrun();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
